holy_lite_data_port: RTL and testbench
======================================

HOLY_LITE_DATA_PORT -- requirements
Module: holy_lite_data_port

Interface
REQ-001 SHALL have parameter WB_DEPTH, default 4, posted-write buffer depth (power of 2, 2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, CPU/AXI address width (AXI-Lite data fixed at 32 bits).
REQ-003 SHALL have port clk  in  1  the only clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports address  in  ADDR_WIDTH; write_data  in  32; byte_enable  in  4; read_enable  in  1; write_enable  in  1 (CPU request, held until stall low).
REQ-006 SHALL have ports read_data  out  32 (last read result); cache_stall  out  1 (CPU must hold request).
REQ-007 SHALL have port axi_lite  axi_lite_if.master  AXI-Lite master bus.
REQ-008 SHALL have ports cache_state  out  cache_state_t (current FSM state for arbiter); wb_count  out  $clog2(WB_DEPTH)+1 (buffer occupancy).

Function
REQ-009 SHALL treat a write as valid only when write_enable and |byte_enable; zero-strobe writes cause no buffer change and no stall.
REQ-010 SHALL push {address, write_data, byte_enable} into the write buffer in the cycle of a valid write when wb_count < WB_DEPTH at cycle start, cache_stall low that cycle.
REQ-011 SHALL, on valid write with buffer full, assert cache_stall combinationally until a cycle with wb_count < WB_DEPTH at cycle start; no same-cycle pop/push pass-through when full.
REQ-012 SHALL keep FSM states IDLE, LITE_SENDING_WRITE_REQ, LITE_WAITING_WRITE_RES, LITE_SENDING_READ_REQ, LITE_RECEIVING_READ_DATA, driven on cache_state.
REQ-013 SHALL, in IDLE with buffer non-empty, enter LITE_SENDING_WRITE_REQ, driving awvalid and wvalid together from buffer head, wstrb = stored byte_enable.
REQ-014 SHALL drop awvalid after its handshake and wvalid after its own, independently; enter LITE_WAITING_WRITE_RES when both done (same or different cycles).
REQ-015 SHALL assert bready in LITE_WAITING_WRITE_RES; on bvalid pop buffer head, return IDLE.
REQ-016 SHALL stall a read until buffer empty and FSM IDLE (read-after-write ordering), then enter LITE_SENDING_READ_REQ with arvalid, araddr = address.
REQ-017 SHALL enter LITE_RECEIVING_READ_DATA on arready, assert rready, capture rdata into read_data on rvalid, return IDLE.
REQ-018 SHALL hold cache_stall high for a read from request cycle through R handshake cycle, low the following cycle with read_data valid; a one-cycle done flag prevents reissuing the same held read.
REQ-019 SHALL, with read_enable and write_enable both high, perform the read and discard the write.
REQ-020 SHALL deassert all valid/ready outputs in IDLE; awaddr/wdata/araddr stable while corresponding valid high.
REQ-021 SHALL give bvalid-pop and CPU push in the same cycle a net wb_count change of zero.

Reset
REQ-022 SHALL, on rst_n low asynchronously: state IDLE, buffer empty, wb_count 0, read_data 0, cache_stall 0 (absent requests), awvalid/wvalid/arvalid/bready/rready 0.
REQ-023 SHALL abandon any in-flight transaction and discard buffered writes on reset mid-operation.

Configuration
REQ-024 SHALL, with HOLY_LITE_BUS_ERR_EN defined, add outputs bus_err (1) and bus_err_addr (ADDR_WIDTH): one-cycle pulse with failing address on bresp!=0 or rresp!=0.
REQ-025 SHALL, without HOLY_LITE_BUS_ERR_EN, omit those ports and ignore bresp/rresp; transaction flow identical in both builds.

Verification
REQ-026 Single write 0x1000=0xDEADBEEF be=0011 -> no stall, one AW/W pair, wstrb=0011, wb_count 1->0 after bvalid.
REQ-027 Five back-to-back writes, WB_DEPTH=4, slave bvalid delayed 10 cycles -> first four unstalled, fifth stalled until first B, AXI order preserved.
REQ-028 Write 0x2000=0x55 then read 0x2000 next cycle -> AR only after B; read_data=0x55, stall low cycle after R.
REQ-029 awready 3 cycles before wready, then reversed -> each valid drops after own handshake, exactly one B wait each.
REQ-030 rst_n low during LITE_RECEIVING_READ_DATA with 2 buffered writes -> all valids 0, wb_count 0, state IDLE immediately.
REQ-031 HOLY_LITE_BUS_ERR_EN build, bresp=2'b10 on write to 0x3000 -> bus_err one-cycle pulse, bus_err_addr=0x3000, entry popped.

Source files
------------

// File: rtl/holy_lite_data_port_if.sv
// Shared types and the AXI-Lite bus bundle for the holy_lite data port.
// Latency: n/a (type and interface declarations only).
// Backpressure: n/a; the valid/ready pairs are carried unchanged between master and slave.
//
// holy_lite_pkg::cache_state_t : FSM state exported to the arbiter.
// axi_lite_if                  : AXI-Lite channels AW/W/B/AR/R, 32-bit data, ADDR_WIDTH address.

package holy_lite_pkg;
    typedef enum logic [2:0] {
        IDLE                     = 3'd0,
        LITE_SENDING_WRITE_REQ   = 3'd1,
        LITE_WAITING_WRITE_RES   = 3'd2,
        LITE_SENDING_READ_REQ    = 3'd3,
        LITE_RECEIVING_READ_DATA = 3'd4
    } cache_state_t;
endpackage

interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/holy_lite_data_port.sv
// CPU data port: posted-write buffer draining to an AXI-Lite master, reads ordered behind writes.
// Latency: writes post in 0 cycles when the buffer has room; reads return the cycle after the R handshake.
// Backpressure: cache_stall holds the CPU while the buffer is full (write) or until read data returns (read).
//
// Ports: clk, rst_n (async active-low); CPU side address/write_data/byte_enable/read_enable/write_enable,
//        read_data, cache_stall; axi_lite (master); cache_state, wb_count status.
// Build option: define HOLY_LITE_BUS_ERR_EN to add bus_err / bus_err_addr, a one-cycle pulse
//        carrying the failing address when bresp or rresp is non-zero.

// Generic FIFO used as the posted-write buffer. No pass-through: push is refused when the
// occupancy at the start of the cycle equals DEPTH, even if a pop happens in the same cycle.
// Latency: one cycle from push to head; Backpressure: full_o, pushes while full are dropped.
module holy_lite_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

module holy_lite_data_port
    import holy_lite_pkg::*;
#(
    parameter int WB_DEPTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [31:0]               write_data,
    input  logic [3:0]                byte_enable,
    input  logic                      read_enable,
    input  logic                      write_enable,
    output logic [31:0]               read_data,
    output logic                      cache_stall,
    output cache_state_t              cache_state,
    output logic [$clog2(WB_DEPTH):0] wb_count,
`ifdef HOLY_LITE_BUS_ERR_EN
    output logic                      bus_err,
    output logic [ADDR_WIDTH-1:0]     bus_err_addr,
`endif
    axi_lite_if.master                axi_lite
);
    localparam int CW    = $clog2(WB_DEPTH) + 1;
    localparam int ENT_W = ADDR_WIDTH + 32 + 4;

    cache_state_t          state_q, state_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  rd_done_q, rd_done_d;

    logic                  wr_req, rd_req, rd_hs;
    logic                  wb_push, wb_pop, wb_full, wb_empty;
    logic [ENT_W-1:0]      wb_head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [31:0]           head_data;
    logic [3:0]            head_be;
    logic [CW-1:0]         wb_count_w;

    // A read wins over a simultaneous write; the write is dropped, not deferred.
    assign wr_req  = write_enable && (|byte_enable) && !read_enable;
    // rd_done_q marks the cycle the CPU consumes read_data, so the still-held
    // request is not mistaken for a new read.
    assign rd_req  = read_enable && !rd_done_q;
    assign wb_push = wr_req && !wb_full;
    assign wb_pop  = (state_q == LITE_WAITING_WRITE_RES) && axi_lite.bvalid;
    assign rd_hs   = (state_q == LITE_RECEIVING_READ_DATA) && axi_lite.rvalid;

    holy_lite_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (wb_push),
        .push_dat_i ({address, write_data, byte_enable}),
        .pop_i      (wb_pop),
        .head_dat_o (wb_head),
        .count_o    (wb_count_w),
        .full_o     (wb_full),
        .empty_o    (wb_empty)
    );

    assign {head_addr, head_data, head_be} = wb_head;

    always_comb begin
        state_d     = state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        araddr_d    = araddr_q;
        read_data_d = read_data_q;
        rd_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Buffered writes drain before any read so reads see prior writes.
                if (!wb_empty) begin
                    state_d   = LITE_SENDING_WRITE_REQ;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                end else if (rd_req) begin
                    state_d  = LITE_SENDING_READ_REQ;
                    araddr_d = address;
                end
            end
            LITE_SENDING_WRITE_REQ: begin
                // AW and W complete independently; leave once both have handshaken.
                aw_pend_d = aw_pend_q && !axi_lite.awready;
                w_pend_d  = w_pend_q && !axi_lite.wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = LITE_WAITING_WRITE_RES;
                end
            end
            LITE_WAITING_WRITE_RES: begin
                if (axi_lite.bvalid) begin
                    state_d = IDLE;
                end
            end
            LITE_SENDING_READ_REQ: begin
                if (axi_lite.arready) begin
                    state_d = LITE_RECEIVING_READ_DATA;
                end
            end
            LITE_RECEIVING_READ_DATA: begin
                if (axi_lite.rvalid) begin
                    read_data_d = axi_lite.rdata;
                    rd_done_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            araddr_q    <= '0;
            read_data_q <= '0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            araddr_q    <= araddr_d;
            read_data_q <= read_data_d;
            rd_done_q   <= rd_done_d;
        end
    end

    // Write channel fields come straight from the buffer head, which cannot
    // move until the B handshake, so they stay stable while valid is high.
    assign axi_lite.awvalid = (state_q == LITE_SENDING_WRITE_REQ) && aw_pend_q;
    assign axi_lite.wvalid  = (state_q == LITE_SENDING_WRITE_REQ) && w_pend_q;
    assign axi_lite.awaddr  = head_addr;
    assign axi_lite.wdata   = head_data;
    assign axi_lite.wstrb   = head_be;
    assign axi_lite.bready  = (state_q == LITE_WAITING_WRITE_RES);
    assign axi_lite.arvalid = (state_q == LITE_SENDING_READ_REQ);
    assign axi_lite.araddr  = araddr_q;
    assign axi_lite.rready  = (state_q == LITE_RECEIVING_READ_DATA);

    assign cache_stall = (wr_req && wb_full) || rd_req;
    assign read_data   = read_data_q;
    assign cache_state = state_q;
    assign wb_count    = wb_count_w;

`ifdef HOLY_LITE_BUS_ERR_EN
    logic                  bus_err_q;
    logic [ADDR_WIDTH-1:0] bus_err_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= '0;
        end else begin
            bus_err_q <= 1'b0;
            if (wb_pop && (axi_lite.bresp != 2'b00)) begin
                bus_err_q      <= 1'b1;
                bus_err_addr_q <= head_addr;
            end else if (rd_hs && (axi_lite.rresp != 2'b00)) begin
                bus_err_q      <= 1'b1;
                bus_err_addr_q <= araddr_q;
            end
        end
    end

    assign bus_err      = bus_err_q;
    assign bus_err_addr = bus_err_addr_q;
`endif
endmodule

// File: tb/tb_holy_lite_data_port.sv
// Bench for holy_lite_data_port: a randomized AXI-Lite slave plus a CPU driver.
// Expected values come from a memory/occupancy model of the port's behaviour.

module tb_holy_lite_data_port;
    import holy_lite_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] address;
    logic [31:0]   write_data;
    logic [3:0]    byte_enable;
    logic          read_enable;
    logic          write_enable;
    logic [31:0]   read_data;
    logic          cache_stall;
    cache_state_t  cache_state;
    logic [CW-1:0] wb_count;
`ifdef HOLY_LITE_BUS_ERR_EN
    logic          bus_err;
    logic [AW-1:0] bus_err_addr;
`endif

    axi_lite_if #(.ADDR_WIDTH(AW)) bus ();

    holy_lite_data_port #(.WB_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .write_data   (write_data),
        .byte_enable  (byte_enable),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .read_data    (read_data),
        .cache_stall  (cache_stall),
        .cache_state  (cache_state),
        .wb_count     (wb_count),
`ifdef HOLY_LITE_BUS_ERR_EN
        .bus_err      (bus_err),
        .bus_err_addr (bus_err_addr),
`endif
        .axi_lite     (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    int  n_cmp = 0;
    int  n_err = 0;
    int  n_acc = 0;   // writes the CPU got accepted
    int  n_b   = 0;   // B handshakes seen
    int  n_r   = 0;   // R handshakes seen
    time last_r_time = 0;

    int rdy_pct = 100;
    int b_dmin = 0, b_dmax = 0, r_dmin = 0, r_dmax = 0;

    wr_t         exp_q[$];
    wr_t         w_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] mmem[logic [31:0]];
    logic [31:0] smem[logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] mget(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
            $error("check %s differs", tag);
        end
    endtask

    // ---------------- AXI-Lite slave ----------------
    // Runs on the falling edge: first retires handshakes flagged for the rising
    // edge just past, then drives new ready/valid values and flags the
    // handshakes that will occur at the next rising edge.
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, b_wait, r_wait;
    int          b_timer, r_timer;
    logic [31:0] aw_flag, ar_flag, ar_cur, b_addr, pa;
    wr_t         w_flag, pw, pe;

    initial begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.rvalid = 1'b0;
        bus.rdata = '0; bus.rresp = 2'b00;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, b_wait, r_wait} = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_q.delete(); w_q.delete(); smem.delete();
                {aw_hs, w_hs, b_hs, ar_hs, r_hs, b_wait, r_wait} = '0;
                bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
                bus.bvalid = 1'b0; bus.rvalid = 1'b0;
            end else begin
                if (aw_hs) aw_q.push_back(aw_flag);
                if (w_hs) w_q.push_back(w_flag);
                if (b_hs) begin bus.bvalid = 1'b0; bus.bresp = 2'b00; n_b++; end
                if (r_hs) begin bus.rvalid = 1'b0; n_r++; last_r_time = $time; end
                if (ar_hs) begin
                    check("ar_after_all_b", 64'(n_b), 64'(n_acc));
                    ar_cur  = ar_flag;
                    r_timer = int'($urandom_range(r_dmax, r_dmin));
                    r_wait  = 1'b1;
                end
                if (aw_q.size() > 0 && w_q.size() > 0) begin
                    pa = aw_q.pop_front();
                    pw = w_q.pop_front();
                    check("axi_write_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        pe = exp_q.pop_front();
                        check("axi_awaddr_order", 64'(pa), 64'(pe.a));
                        check("axi_wdata", 64'(pw.d), 64'(pe.d));
                        check("axi_wstrb", 64'(pw.be), 64'(pe.be));
                    end
                    smem[pa] = merge(smem.exists(pa) ? smem[pa] : init_val(pa), pw.d, pw.be);
                    b_addr  = pa;
                    b_timer = int'($urandom_range(b_dmax, b_dmin));
                    b_wait  = 1'b1;
                end
                if (b_wait) begin
                    if (b_timer == 0) begin
                        bus.bvalid = 1'b1;
                        bus.bresp  = (b_addr == 32'h3000) ? 2'b10 : 2'b00;
                        b_wait     = 1'b0;
                    end else b_timer--;
                end
                if (r_wait) begin
                    if (r_timer == 0) begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = smem.exists(ar_cur) ? smem[ar_cur] : init_val(ar_cur);
                        r_wait     = 1'b0;
                    end else r_timer--;
                end
                bus.awready = (int'($urandom_range(99)) < rdy_pct);
                bus.wready  = (int'($urandom_range(99)) < rdy_pct);
                bus.arready = (int'($urandom_range(99)) < rdy_pct);
                aw_hs = bus.awvalid && bus.awready; aw_flag = bus.awaddr;
                w_hs  = bus.wvalid && bus.wready;   w_flag = {32'h0, bus.wdata, bus.wstrb};
                ar_hs = bus.arvalid && bus.arready; ar_flag = bus.araddr;
                b_hs  = bus.bvalid && bus.bready;
                r_hs  = bus.rvalid && bus.rready;
            end
        end
    end

    // ---------------- CPU side ----------------
    task automatic drive(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        read_enable = re; write_enable = we; address = a; write_data = d; byte_enable = be;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            check("idle_stall", 64'(cache_stall), 64'(0));
            check("idle_wb_count", 64'(wb_count), 64'(n_acc - n_b));
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bit exp_stall, done;
        int guard;
        done = 1'b0; guard = 0;
        @(negedge clk); #1;
        drive(1'b0, 1'b1, a, d, be);
        while (!done) begin
            #1;
            exp_stall = (be != 4'h0) && ((n_acc - n_b) == DEPTH);
            check("wr_stall", 64'(cache_stall), 64'(exp_stall));
            check("wr_wb_count", 64'(wb_count), 64'(n_acc - n_b));
            if (!exp_stall) begin
                if (be != 4'h0) begin
                    n_acc++;
                    exp_q.push_back({a, d, be});
                    mmem[a] = merge(mget(a), d, be);
                end
                done = 1'b1;
            end else if (guard > 300) begin
                check("wr_stall_timeout", 64'(guard), 64'(0));
                done = 1'b1;
            end else begin
                guard++;
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic also_wr, input logic [31:0] d);
        int  n_r0, guard;
        bit  done;
        n_r0 = n_r; guard = 0; done = 1'b0;
        @(negedge clk); #1;
        drive(1'b1, also_wr, a, d, 4'hF);
        #1;
        check("rd_stall_first", 64'(cache_stall), 64'(1));
        while (!done) begin
            @(negedge clk); #2;
            if (!cache_stall) done = 1'b1;
            else if (++guard > 400) begin
                check("rd_stall_timeout", 64'(cache_stall), 64'(0));
                done = 1'b1;
            end
        end
        check("rd_one_r", 64'(n_r), 64'(n_r0 + 1));
        check("rd_release_after_r", 64'($time - last_r_time), 64'(2));
        check("rd_data", 64'(read_data), 64'(mget(a)));
        check("rd_wb_count", 64'(wb_count), 64'(n_acc - n_b));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, 64'(bus.awvalid), 64'(0));
        check({tag, "_wvalid"}, 64'(bus.wvalid), 64'(0));
        check({tag, "_arvalid"}, 64'(bus.arvalid), 64'(0));
        check({tag, "_bready"}, 64'(bus.bready), 64'(0));
        check({tag, "_rready"}, 64'(bus.rready), 64'(0));
        check({tag, "_wb_count"}, 64'(wb_count), 64'(0));
        check({tag, "_state"}, 64'(cache_state), 64'(IDLE));
        check({tag, "_read_data"}, 64'(read_data), 64'(0));
        check({tag, "_stall"}, 64'(cache_stall), 64'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk); #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check_reset_outputs(tag);
        n_acc = 0; n_b = 0; exp_q.delete(); mmem.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [31:0] a, d;
        logic [3:0]  be;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("por");
        #1 rst_n = 1'b1;

        // Single write with partial strobe, then drain.
        cpu_write(32'h1000, 32'hDEAD_BEEF, 4'b0011);
        idle(6);

        // Five back-to-back writes against a slow B channel: fifth must stall.
        b_dmin = 10; b_dmax = 10;
        for (int i = 0; i < 5; i++) cpu_write(32'h1100 + 32'(4 * i), 32'h100 + 32'(i), 4'hF);
        idle(40);

        // Read right behind a write to the same address.
        b_dmin = 0; b_dmax = 0;
        cpu_write(32'h2000, 32'h55, 4'hF);
        cpu_read(32'h2000, 1'b0, 32'h0);
        idle(2);

        // Randomized mix with random ready/valid timing.
        rdy_pct = 50; b_dmin = 0; b_dmax = 4; r_dmin = 0; r_dmax = 3;
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(9));
            a  = 32'h1000 + 32'(4 * $urandom_range(3));
            d  = $urandom;
            be = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom_range(15));
            if (op <= 5) cpu_write(a, d, be);
            else if (op <= 7) cpu_read(a, 1'b0, d);
            else if (op == 8) cpu_read(a, 1'b1, d);
            else idle(int'($urandom_range(3, 1)));
        end
        idle(20);

        // Reset with writes buffered and one in flight.
        rdy_pct = 100; b_dmin = 20; b_dmax = 20;
        for (int i = 0; i < 3; i++) cpu_write(32'h1200 + 32'(4 * i), $urandom, 4'hF);
        idle(2);
        do_reset("rst_mid_write");
        b_dmin = 0; b_dmax = 0;

        // Reset while waiting on read data.
        r_dmin = 20; r_dmax = 20;
        cpu_write(32'h1008, 32'hCAFE_F00D, 4'hF);
        idle(4);
        @(negedge clk); #1;
        drive(1'b1, 1'b0, 32'h1008, 32'h0, 4'h0);
        guard = 0;
        while (cache_state != LITE_RECEIVING_READ_DATA && guard < 100) begin
            @(negedge clk); #2;
            guard++;
        end
        check("reach_recv_state", 64'(cache_state), 64'(LITE_RECEIVING_READ_DATA));
        do_reset("rst_mid_read");
        r_dmin = 0; r_dmax = 0;
        idle(25);

        // Port works normally after reset.
        cpu_write(32'h1004, 32'h1234_5678, 4'b1100);
        cpu_read(32'h1004, 1'b0, 32'h0);
        idle(2);

`ifdef HOLY_LITE_BUS_ERR_EN
        cpu_write(32'h3000, 32'h0BAD_0BAD, 4'hF);
        guard = 0;
        do begin
            @(negedge clk); #1;
            drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            guard++;
        end while (!bus_err && guard < 50);
        check("bus_err_pulse", 64'(bus_err), 64'(1));
        check("bus_err_addr", 64'(bus_err_addr), 64'(32'h3000));
        check("bus_err_popped", 64'(wb_count), 64'(0));
        @(negedge clk); #2;
        check("bus_err_one_cycle", 64'(bus_err), 64'(0));
`endif

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
